// File: rtl/multdiv_exec_unit.sv
// rtl/multdiv_exec_unit.sv - iterative signed multiply/divide execution unit
//
// Purpose
//   Accepts one multiply or divide per issue. It runs the operation over 32
//   iterations, one per clock, and returns the result, an exception flag and the
//   destination tag to the writeback mux. While an operation is in flight, stall
//   freezes the upstream pipeline stages.
//
// Configuration macro
//   MULTDIV_EARLY_OUT_EN : when defined, a multiply with a zero operand and a
//                          divide by zero finish in the cycle after issue.
//
// Ports
//   clock           in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   ctrl_mult       in   issue pulse, multiply (wins over ctrl_div)
//   ctrl_div        in   issue pulse, divide
//   data_operandA   in   operand A (latched at issue)
//   data_operandB   in   operand B (latched at issue)
//   in_rd           in   destination tag (latched at issue)
//   busy            out  operation iterating (MULT or DIV state)
//   stall           out  busy, or an issue being accepted this cycle
//   data_result     out  low product word / signed quotient, held until next completion
//   data_exception  out  overflow or divide-by-zero, qualified by data_resultRDY
//   data_resultRDY  out  one-cycle result-valid pulse
//   out_rd          out  tag of the completed operation, held until next completion

module multdiv_exec_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [TAG_W-1:0] in_rd,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [TAG_W-1:0] out_rd
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;

    // Shared datapath. For a multiply, {acc_q, mq_q, qm1_q} is the Booth product
    // register. For a divide, acc_q is the partial remainder and mq_q shifts the
    // dividend out while the quotient bits shift in. acc_q carries two guard bits.
    // One guard bit keeps the Booth accumulator exact when the multiplicand is the
    // most negative value. The other keeps the doubled remainder in range when
    // the divisor magnitude is 2^(WIDTH-1).
    logic [WIDTH+1:0] acc_q;
    logic [WIDTH-1:0] mq_q;
    logic             qm1_q;
    logic [WIDTH-1:0] mcand_q;    // multiplicand A, or divisor magnitude |B|
    logic             neg_q;      // quotient must be negated in the sign fix-up
    logic             dbz_q;      // divide by zero
    logic             ovf_q;      // most-negative / -1
    logic [TAG_W-1:0] rd_q;

    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;
    logic [TAG_W-1:0] out_rd_q;

    // Issue decode
    logic issue_ok;
    logic issue_mult;
    logic issue_div;
    logic early_mult;
    logic early_div;

    assign issue_ok   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign issue_mult = issue_ok && ctrl_mult;
    assign issue_div  = issue_ok && ctrl_div && !ctrl_mult;

`ifdef MULTDIV_EARLY_OUT_EN
    assign early_mult = (data_operandA == '0) || (data_operandB == '0);
    assign early_div  = (data_operandB == '0);
`else
    assign early_mult = 1'b0;
    assign early_div  = 1'b0;
`endif

    assign busy  = (state_q == S_MULT) || (state_q == S_DIV);
    assign stall = busy || issue_mult || issue_div;

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign out_rd         = out_rd_q;

    // Operand magnitudes for the divider. The negation of MIN_NEG wraps to
    // itself, and that value is read as the unsigned magnitude 2^(WIDTH-1).
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // One iteration of the active algorithm
    logic [WIDTH+1:0] mcand_ext;
    logic [WIDTH+1:0] div_d;
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] acc_n;
    logic [WIDTH-1:0] mq_n;
    logic             qm1_n;

    assign mcand_ext = {{2{mcand_q[WIDTH-1]}}, mcand_q};
    assign div_d     = {2'b00, mcand_q};

    always_comb begin
        sum     = acc_q;
        shifted = '0;
        acc_n   = acc_q;
        mq_n    = mq_q;
        qm1_n   = qm1_q;
        if (state_q == S_MULT) begin
            // Radix-2 Booth: pair {q0, q-1} selects +A, -A or nothing, then the
            // whole product register shifts right arithmetically.
            case ({mq_q[0], qm1_q})
                2'b01:   sum = acc_q + mcand_ext;
                2'b10:   sum = acc_q - mcand_ext;
                default: sum = acc_q;
            endcase
            acc_n = {sum[WIDTH+1], sum[WIDTH+1:1]};
            mq_n  = {sum[0], mq_q[WIDTH-1:1]};
            qm1_n = mq_q[0];
        end else begin
            // Non-restoring: subtract when the partial remainder is non-negative,
            // add back otherwise. The quotient bit is 1 when the new remainder
            // is non-negative. The final remainder is never needed, so it gets
            // no correction step.
            shifted = {acc_q[WIDTH:0], mq_q[WIDTH-1]};
            sum     = acc_q[WIDTH+1] ? (shifted + div_d) : (shifted - div_d);
            acc_n   = sum;
            mq_n    = {mq_q[WIDTH-2:0], ~sum[WIDTH+1]};
        end
    end

    // Result and exception as seen after the last iteration
    logic [WIDTH:0]   hi_bits;
    logic [WIDTH-1:0] fin_result;
    logic             fin_exc;

    assign hi_bits = {acc_n[WIDTH-1:0], mq_n[WIDTH-1]};

    always_comb begin
        fin_result = mq_n;
        fin_exc    = 1'b0;
        if (state_q == S_MULT) begin
            // The product fits in WIDTH bits only if its upper half and the
            // sign bit of the low word are all equal.
            fin_result = mq_n;
            fin_exc    = !((&hi_bits) || !(|hi_bits));
        end else if (dbz_q) begin
            fin_result = '0;
            fin_exc    = 1'b1;
        end else if (ovf_q) begin
            fin_result = MIN_NEG;
            fin_exc    = 1'b1;
        end else begin
            fin_result = neg_q ? -mq_n : mq_n;
            fin_exc    = 1'b0;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            qm1_q    <= 1'b0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            out_rd_q <= '0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    count_q <= '0;
                    if (issue_mult) begin
                        rd_q <= in_rd;
                        if (early_mult) begin
                            state_q  <= S_DONE;
                            result_q <= '0;
                            exc_q    <= 1'b0;
                            rdy_q    <= 1'b1;
                            out_rd_q <= in_rd;
                        end else begin
                            state_q <= S_MULT;
                            acc_q   <= '0;
                            mq_q    <= data_operandB;
                            qm1_q   <= 1'b0;
                            mcand_q <= data_operandA;
                        end
                    end else if (issue_div) begin
                        rd_q <= in_rd;
                        if (early_div) begin
                            state_q  <= S_DONE;
                            result_q <= '0;
                            exc_q    <= 1'b1;
                            rdy_q    <= 1'b1;
                            out_rd_q <= in_rd;
                        end else begin
                            state_q <= S_DIV;
                            acc_q   <= '0;
                            mq_q    <= a_mag;
                            qm1_q   <= 1'b0;
                            mcand_q <= b_mag;
                            neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                            dbz_q   <= (data_operandB == '0);
                            ovf_q   <= (data_operandA == MIN_NEG) && (&data_operandB);
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MULT, S_DIV: begin
                    acc_q   <= acc_n;
                    mq_q    <= mq_n;
                    qm1_q   <= qm1_n;
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == LAST_ITER) begin
                        state_q  <= S_DONE;
                        result_q <= fin_result;
                        exc_q    <= fin_exc;
                        rdy_q    <= 1'b1;
                        out_rd_q <= rd_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_exec_unit.sv
// tb/tb_multdiv_exec_unit.sv - self-checking bench for multdiv_exec_unit
module tb_multdiv_exec_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_mult = 1'b0;
    logic        ctrl_div = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [4:0]  in_rd = '0;
    logic        busy;
    logic        stall;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [4:0]  out_rd;

    typedef struct packed {
        logic [31:0] res;
        logic        exc;
        logic [4:0]  rd;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rdy_count = 0;
    int   last_rdy_cyc = 0;
    int   issue_cyc = 0;
    exp_t sb[$];

`ifdef MULTDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    multdiv_exec_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_mult      (ctrl_mult),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .in_rd          (in_rd),
        .busy           (busy),
        .stall          (stall),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .out_rd         (out_rd)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard consumer: every result pulse pops one expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                rdy_count++;
                last_rdy_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_rdy got result=%h exc=%b rd=%0d expected no pulse",
                             data_result, data_exception, out_rd);
                end else begin
                    e = sb.pop_front();
                    if (data_result !== e.res) begin
                        failures++;
                        $display("FAIL sb_result got=%h expected=%h", data_result, e.res);
                    end
                    checks++;
                    if (data_exception !== e.exc) begin
                        failures++;
                        $display("FAIL sb_exception got=%b expected=%b", data_exception, e.exc);
                    end
                    checks++;
                    if (out_rd !== e.rd) begin
                        failures++;
                        $display("FAIL sb_out_rd got=%0d expected=%0d", out_rd, e.rd);
                    end
                end
            end
        end
    end

    function automatic exp_t model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] rd);
        exp_t r;
        logic signed [63:0] p;
        r.rd = rd;
        if (m) begin
            p     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r.res = p[31:0];
            r.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r.res = 32'd0;
            r.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.res = 32'h8000_0000;
            r.exc = 1'b1;
        end else begin
            r.res = $signed(a) / $signed(b);
            r.exc = 1'b0;
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input exp_t e, input bit expect_rdy);
        ctrl_mult     = m;
        ctrl_div      = d;
        data_operandA = a;
        data_operandB = b;
        in_rd         = rd;
        issue_cyc     = cyc;
        if (expect_rdy) sb.push_back(e);
    endtask

    // Clears issue and scrambles operands each cycle so that later input
    // changes cannot leak into a latched operation.
    task automatic wait_rdy(input int target, input int budget, output bit ok, output int busy_cycles);
        ok = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ctrl_mult     = 1'b0;
            ctrl_div      = 1'b0;
            data_operandA = $urandom;
            data_operandB = $urandom;
            in_rd         = 5'($urandom);
            if (busy === 1'b1) busy_cycles++;
            if (rdy_count >= target) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b expected=0", stall); end
        checks++; if (data_result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h expected=0", data_result); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL reset_exc got=%b expected=0", data_exception); end
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b expected=0", data_resultRDY); end
        checks++; if (out_rd !== 5'd0) begin failures++; $display("FAIL reset_out_rd got=%0d expected=0", out_rd); end
        reset = 1'b1;
        tick();
    endtask

    // Issues one operation, waits for its result and checks latency.
    task automatic run_op(input string name, input bit m, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input exp_t e, input int lat);
        int  target;
        bit  ok;
        int  bc;
        target = rdy_count + 1;
        tick();
        issue(m, !m, a, b, rd, e, 1'b1);
        wait_rdy(target, 60, ok, bc);
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_timeout got=no_rdy expected=rdy", name); end
        checks++;
        if (last_rdy_cyc - issue_cyc != lat) begin
            failures++;
            $display("FAIL %s_latency got=%0d expected=%0d", name, last_rdy_cyc - issue_cyc, lat);
        end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL %s_done_stall got=%b expected=0", name, stall); end
    endtask

    task automatic test_mult_basic();
        int  target;
        bit  ok;
        int  bc;
        target = rdy_count + 1;
        tick();
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, {32'hFFFF_FFEB, 1'b0, 5'd5}, 1'b1);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mult_issue_stall got=%b expected=1", stall); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult_issue_busy got=%b expected=0", busy); end
        wait_rdy(target, 60, ok, bc);
        checks++; if (!ok) begin failures++; $display("FAIL mult_timeout got=no_rdy expected=rdy"); end
        checks++;
        if (last_rdy_cyc - issue_cyc != 33) begin
            failures++; $display("FAIL mult_latency got=%0d expected=33", last_rdy_cyc - issue_cyc);
        end
        checks++; if (bc != 32) begin failures++; $display("FAIL mult_busy_cycles got=%0d expected=32", bc); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mult_done_stall got=%b expected=0", stall); end
        tick();
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL mult_rdy_width got=%b expected=0", data_resultRDY); end
        checks++; if (data_result !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_hold got=%h expected=ffffffeb", data_result); end
        checks++; if (out_rd !== 5'd5) begin failures++; $display("FAIL mult_hold_rd got=%0d expected=5", out_rd); end
    endtask

    task automatic test_div();
        run_op("div_pos_neg", 1'b0, 32'd100, 32'hFFFF_FFF9, 5'd1, {32'hFFFF_FFF2, 1'b0, 5'd1}, 33);
        run_op("div_neg_pos", 1'b0, 32'hFFFF_FF9C, 32'd7, 5'd2, {32'hFFFF_FFF2, 1'b0, 5'd2}, 33);
        run_op("div_neg_neg", 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd3, {32'd14, 1'b0, 5'd3}, 33);
        run_op("div_min_pos1", 1'b0, 32'h8000_0000, 32'd1, 5'd4, {32'h8000_0000, 1'b0, 5'd4}, 33);
    endtask

    task automatic test_zero_cases();
        run_op("div_by_zero", 1'b0, 32'd5, 32'd0, 5'd4, {32'd0, 1'b1, 5'd4}, EARLY_LAT);
        run_op("mult_zero", 1'b1, 32'd0, 32'd123, 5'd11, {32'd0, 1'b0, 5'd11}, EARLY_LAT);
    endtask

    task automatic test_overflow();
        run_op("mult_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000, 5'd6, {32'd0, 1'b1, 5'd6}, 33);
        run_op("mult_max", 1'b1, 32'h7FFF_FFFF, 32'd1, 5'd7, {32'h7FFF_FFFF, 1'b0, 5'd7}, 33);
        run_op("mult_min_neg1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, {32'h8000_0000, 1'b1, 5'd12}, 33);
        run_op("mult_neg_min", 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 5'd13, {32'h8000_0000, 1'b1, 5'd13}, 33);
        run_op("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, {32'h8000_0000, 1'b1, 5'd8}, 33);
    endtask

    task automatic test_ignore_and_reset();
        int  target;
        bit  ok;
        int  bc;
        int  rc;
        target = rdy_count + 1;
        tick();
        issue(1'b1, 1'b0, 32'd1234, 32'hFFFF_FFC8, 5'd10, model(1'b1, 32'd1234, 32'hFFFF_FFC8, 5'd10), 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick();
            ctrl_mult = 1'b0;
        end
        ctrl_div      = 1'b1;
        data_operandA = 32'd99;
        data_operandB = 32'd3;
        in_rd         = 5'd31;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ignore_stall got=%b expected=1", stall); end
        tick();
        ctrl_div = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy got=%b expected=1", busy); end
        wait_rdy(target, 60, ok, bc);
        checks++; if (!ok) begin failures++; $display("FAIL ignore_timeout got=no_rdy expected=rdy"); end
        checks++;
        if (last_rdy_cyc - issue_cyc != 33) begin
            failures++; $display("FAIL ignore_latency got=%0d expected=33", last_rdy_cyc - issue_cyc);
        end

        // Abort a multiply mid-flight with reset
        tick();
        rc = rdy_count;
        issue(1'b1, 1'b0, 32'd3, 32'd5, 5'd9, '0, 1'b0);
        for (int i = 0; i < 19; i++) begin
            tick();
            ctrl_mult = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_pre_busy got=%b expected=1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b expected=0", busy); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL abort_stall got=%b expected=0", stall); end
        checks++; if (data_result !== 32'd0) begin failures++; $display("FAIL abort_result got=%h expected=0", data_result); end
        checks++; if (out_rd !== 5'd0) begin failures++; $display("FAIL abort_out_rd got=%0d expected=0", out_rd); end
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        checks++; if (rdy_count != rc) begin failures++; $display("FAIL abort_no_rdy got=%0d expected=%0d", rdy_count, rc); end
    endtask

    task automatic test_back_to_back();
        int  target;
        bit  ok;
        int  bc;
        int  c1;
        target = rdy_count + 1;
        tick();
        issue(1'b1, 1'b0, 32'hFFFF_FFF7, 32'd11, 5'd3, {32'hFFFF_FF9D, 1'b0, 5'd3}, 1'b1);
        wait_rdy(target, 60, ok, bc);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_first_timeout got=no_rdy expected=rdy"); end
        c1 = last_rdy_cyc;
        target = rdy_count + 1;
        issue(1'b0, 1'b1, 32'hFFFF_FC18, 32'd33, 5'd9, {32'hFFFF_FFE2, 1'b0, 5'd9}, 1'b1);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_issue_stall got=%b expected=1", stall); end
        wait_rdy(target, 60, ok, bc);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_second_timeout got=no_rdy expected=rdy"); end
        checks++; if (last_rdy_cyc - c1 != 33) begin failures++; $display("FAIL b2b_spacing got=%0d expected=33", last_rdy_cyc - c1); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        bit          m;
        logic [4:0]  rd;
        for (int i = 0; i < 10; i++) begin
            m  = 1'($urandom);
            a  = $urandom;
            b  = (i % 2 == 0) ? $urandom : {{20{a[3]}}, 12'($urandom)};
            if (b == 32'd0) b = 32'd17;
            if (a == 32'd0) a = 32'd29;
            rd = 5'($urandom);
            run_op("random", m, a, b, rd, model(m, a, b, rd), 33);
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_div();
        test_zero_cases();
        test_overflow();
        test_ignore_and_reset();
        test_back_to_back();
        test_random();
        tick();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d expected=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
